// File: rtl/wb_dma_wb_mast_burst.sv
// Burst-capable WISHBONE master for the DMA engine: address auto-increment, bounded
// retry, stalled-strobe watchdog, done/error status and an external-master pass-through.
module wb_dma_wb_mast_burst #(
    parameter int  DW        = 32,
    parameter int  AW        = 32,
    parameter int  BURST_MAX = 8,
    parameter int  RTY_MAX   = 4,
    parameter int  TOUT      = 255,
    localparam int LW        = $clog2(BURST_MAX + 1),
    localparam int SW        = DW / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          wb_data_i,
    output logic [DW-1:0]          wb_data_o,
    output logic [AW-1:0]          wb_addr_o,
    output logic [SW-1:0]          wb_sel_o,
    output logic                   wb_we_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_rty_i,
    input  logic                   mast_go,
    input  logic                   mast_we,
    input  logic [AW-1:0]          mast_adr,
    input  logic [SW-1:0]          mast_sel,
    input  logic [LW-1:0]          mast_len,
    input  logic [DW-1:0]          mast_din,
    output logic [DW-1:0]          mast_dout,
    output logic                   mast_drdy,
    input  logic                   mast_wait,
    output logic                   mast_busy,
    output logic                   mast_done,
    output logic                   mast_err,
    output logic [1:0]             mast_err_code,
    input  logic                   pt_sel,
    input  logic [DW+AW+SW+2:0]    mast_pt_in,
    output logic [DW+2:0]          mast_pt_out
);

    localparam int RW = $clog2(RTY_MAX + 2);
    localparam int TW = $clog2(TOUT + 1);

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_BUS  = 2'd1;
    localparam logic [1:0] CODE_RTY  = 2'd2;
    localparam logic [1:0] CODE_TOUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   beat_q, beat_d;
    logic [RW-1:0]   rty_q, rty_d;
    logic [TW-1:0]   tout_q, tout_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic [LW-1:0]   len_req;
    logic            beat_ack;

    // Requests longer than the burst limit are clamped rather than rejected.
    assign len_req  = (mast_len > LW'(BURST_MAX)) ? LW'(BURST_MAX) : mast_len;
    assign beat_ack = (state_q == BUS) && stb_q && wb_ack_i && !wb_err_i && !wb_rty_i;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        len_d   = len_q;
        beat_d  = beat_q;
        rty_d   = rty_q;
        tout_d  = tout_q;
        dout_d  = dout_q;

        case (state_q)
            IDLE: begin
                if (mast_go) begin
                    code_d = CODE_NONE;
                    beat_d = '0;
                    rty_d  = '0;
                    tout_d = '0;
                    if (mast_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BUS;
                        adr_d   = mast_adr;
                        sel_d   = mast_sel;
                        we_d    = mast_we;
                        len_d   = len_req;
                        cyc_d   = 1'b1;
                        stb_d   = !mast_wait;
                        busy_d  = 1'b1;
                    end
                end
            end

            BUS: begin
                stb_d  = !mast_wait;
                tout_d = '0;
                if (stb_q) begin
                    if (wb_err_i) begin
                        state_d = ERR;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        code_d  = CODE_BUS;
                    end else if (wb_rty_i) begin
                        // A retried beat always leaves one idle strobe cycle before reissue.
                        stb_d = 1'b0;
                        if (rty_q == RW'(RTY_MAX)) begin
                            state_d = ERR;
                            cyc_d   = 1'b0;
                            busy_d  = 1'b0;
                            err_d   = 1'b1;
                            code_d  = CODE_RTY;
                        end else begin
                            rty_d = rty_q + RW'(1);
                        end
                    end else if (wb_ack_i) begin
                        if (!we_q) begin
                            dout_d = wb_data_i;
                        end
                        adr_d  = adr_q + AW'(SW);
                        beat_d = beat_q + LW'(1);
                        rty_d  = '0;
                        if (beat_q + LW'(1) == len_q) begin
                            state_d = DONE;
                            cyc_d   = 1'b0;
                            stb_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else if (tout_q == TW'(TOUT - 1)) begin
                        state_d = ERR;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        code_d  = CODE_TOUT;
                    end else begin
                        tout_d = tout_q + TW'(1);
                    end
                end
            end

            DONE: state_d = IDLE;

            ERR: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= CODE_NONE;
            adr_q   <= '0;
            sel_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            rty_q   <= '0;
            tout_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            rty_q   <= rty_d;
            tout_q  <= tout_d;
            dout_q  <= dout_d;
        end
    end

    // Write data is not registered: the source advances mast_din on each drdy edge.
    assign {wb_data_o, wb_addr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o} =
        pt_sel ? mast_pt_in : {mast_din, adr_q, sel_q, we_q, cyc_q, stb_q};

    assign mast_pt_out   = {wb_data_i, wb_ack_i, wb_err_i, wb_rty_i};
    assign mast_dout     = dout_q;
    assign mast_drdy     = beat_ack;
    assign mast_busy     = busy_q;
    assign mast_done     = done_q;
    assign mast_err      = err_q;
    assign mast_err_code = code_q;

endmodule

// File: tb/tb_wb_dma_wb_mast_burst.sv
// Scoreboard bench for wb_dma_wb_mast_burst: directed bursts against a scripted slave;
// a monitor pops expected beats/terminations whenever the DUT signals drdy/done/err.
module tb_wb_dma_wb_mast_burst;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int LW = 4;

    localparam int KB = 0;
    localparam int KD = 1;
    localparam int KE = 2;

    logic            clk, rst;
    logic [DW-1:0]   wb_data_i, wb_data_o;
    logic [AW-1:0]   wb_addr_o;
    logic [SW-1:0]   wb_sel_o;
    logic            wb_we_o, wb_cyc_o, wb_stb_o;
    logic            wb_ack_i, wb_err_i, wb_rty_i;
    logic            mast_go, mast_we, mast_wait;
    logic [AW-1:0]   mast_adr;
    logic [SW-1:0]   mast_sel;
    logic [LW-1:0]   mast_len;
    logic [DW-1:0]   mast_din, mast_dout;
    logic            mast_drdy, mast_busy, mast_done, mast_err;
    logic [1:0]      mast_err_code;
    logic            pt_sel;
    logic [DW+AW+SW+2:0] mast_pt_in;
    logic [DW+2:0]   mast_pt_out;

    wb_dma_wb_mast_burst dut (
        .clk(clk), .rst(rst),
        .wb_data_i(wb_data_i), .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .mast_go(mast_go), .mast_we(mast_we), .mast_adr(mast_adr), .mast_sel(mast_sel),
        .mast_len(mast_len), .mast_din(mast_din), .mast_dout(mast_dout),
        .mast_drdy(mast_drdy), .mast_wait(mast_wait), .mast_busy(mast_busy),
        .mast_done(mast_done), .mast_err(mast_err), .mast_err_code(mast_err_code),
        .pt_sel(pt_sel), .mast_pt_in(mast_pt_in), .mast_pt_out(mast_pt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        chk_dat;
        logic [3:0]  sel;
        logic        we;
        logic [1:0]  code;
        logic        chk_lat;
    } ev_t;

    ev_t         sbq[$];
    int          resp_q[$];
    logic [31:0] rdata_q[$];
    logic [31:0] stb_log[$];
    logic [31:0] wdata [64];
    int          checks = 0;
    int          errors = 0;
    int          term_cnt = 0;
    int          cyc_n = 0;
    int          last_drdy = 0;
    int          wbeat = 0;
    int          slave_default = 1;
    int          stall_cnt = 0;
    int          gap_cnt = 0;
    int          cyc_cnt = 0;

    assign mast_din = wdata[wbeat[5:0]];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] adr, input logic [31:0] dat, input logic cd,
                             input logic [3:0] sel, input logic we);
        ev_t e;
        e.kind = KB; e.adr = adr; e.dat = dat; e.chk_dat = cd; e.sel = sel; e.we = we;
        e.code = 2'd0; e.chk_lat = 1'b0;
        sbq.push_back(e);
    endtask

    task automatic push_term(input int kind, input logic [1:0] code, input logic [31:0] dat,
                             input logic cd, input logic lat);
        ev_t e;
        e.kind = kind; e.adr = '0; e.dat = dat; e.chk_dat = cd; e.sel = '0; e.we = 1'b0;
        e.code = code; e.chk_lat = lat;
        sbq.push_back(e);
    endtask

    task automatic start(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [3:0] len);
        @(negedge clk);
        mast_we = we; mast_adr = adr; mast_sel = sel; mast_len = len; mast_go = 1'b1;
        @(negedge clk);
        mast_go = 1'b0;
        #1 chk("go_to_stb", wb_stb_o, len != 0);
    endtask

    task automatic wait_term(input int n0, input int lim);
        int k = 0;
        while (term_cnt == n0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("term_reached", term_cnt != n0, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // Scripted slave: responds in the same cycle as the strobe.
    initial begin
        int r;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_data_i = '0;
        forever begin
            @(negedge clk);
            wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
            if (!pt_sel && !rst && wb_cyc_o) begin
                cyc_cnt++;
                if (wb_stb_o) begin
                    stb_log.push_back(wb_addr_o);
                    r = (resp_q.size() > 0) ? resp_q.pop_front() : slave_default;
                    if (r == 1 || r == 4) begin
                        wb_ack_i  = 1;
                        wb_data_i = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hDEAD_BEEF;
                    end
                    if (r == 2) wb_rty_i = 1;
                    if (r == 3 || r == 4) wb_err_i = 1;
                    if (r == 0) stall_cnt++;
                end else begin
                    gap_cnt++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each drdy/done/err presented by the DUT.
    initial begin
        ev_t e;
        int  k;
        logic adv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (adv) wbeat++;
            adv = 1'b0;
            @(negedge clk);
            #2;
            if (mast_drdy) begin
                adv = 1'b1;
                last_drdy = cyc_n;
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_extra_beat: got beat at %0h expected none", wb_addr_o);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_kind", KB, e.kind);
                    chk("beat_adr", wb_addr_o, e.adr);
                    chk("beat_sel", wb_sel_o, e.sel);
                    chk("beat_we", wb_we_o, e.we);
                    if (e.chk_dat) chk("beat_wdata", wb_data_o, e.dat);
                end
            end
            if (mast_done || mast_err) begin
                k = mast_done ? KD : KE;
                term_cnt++;
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_extra_term: got kind %0d expected none", k);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_kind", k, e.kind);
                    chk("term_code", mast_err_code, e.code);
                    chk("term_cyc", wb_cyc_o, 1'b0);
                    chk("term_busy", mast_busy, 1'b0);
                    if (e.chk_dat) chk("term_dout", mast_dout, e.dat);
                    if (e.chk_lat) chk("done_latency", cyc_n - last_drdy, 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [DW+AW+SW+2:0] pv;
        rst = 1; pt_sel = 0; mast_pt_in = '0; mast_go = 0; mast_we = 0; mast_wait = 0;
        mast_adr = '0; mast_sel = '0; mast_len = '0;
        for (int i = 0; i < 64; i++) wdata[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_adr", wb_addr_o, 32'h0);
        chk("rst_busy", mast_busy, 1'b0);
        chk("rst_status", {mast_done, mast_err, mast_err_code}, 4'h0);
        chk("rst_dout", mast_dout, 32'h0);
        rst = 0;
        repeat (2) @(negedge clk);

        // Read burst, zero-wait slave
        rdata_q = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 4; i++) push_beat(32'h100 + 4 * i, 0, 0, 4'hF, 0);
        push_term(KD, 2'd0, 32'hA3, 1, 1);
        n0 = term_cnt;
        start(0, 32'h100, 4'hF, 4);
        wait_term(n0, 50);

        // Write burst with two wait cycles mid-burst
        for (int i = 0; i < 3; i++) begin
            wdata[(wbeat + i) % 64] = 32'hD000_0000 + i;
            push_beat(32'h600 + 4 * i, 32'hD000_0000 + i, 1, 4'h3, 1);
        end
        push_term(KD, 2'd0, 0, 0, 1);
        n0 = term_cnt;
        start(1, 32'h600, 4'h3, 3);
        mast_wait = 1;
        @(negedge clk); #1;
        chk("wait_stb0", {wb_cyc_o, wb_stb_o}, 2'b10);
        @(negedge clk); mast_wait = 0; #1;
        chk("wait_stb1", {wb_cyc_o, wb_stb_o}, 2'b10);
        @(negedge clk); #1;
        chk("wait_resume", {wb_cyc_o, wb_stb_o}, 2'b11);
        wait_term(n0, 50);

        // Two retries on beat 1, then completion
        stb_log = {}; gap_cnt = 0;
        resp_q = {1, 2, 2, 1, 1};
        rdata_q = {32'hB0, 32'hB1, 32'hB2};
        for (int i = 0; i < 3; i++) push_beat(32'h200 + 4 * i, 0, 0, 4'hF, 0);
        push_term(KD, 2'd0, 32'hB2, 1, 1);
        n0 = term_cnt;
        start(0, 32'h200, 4'hF, 3);
        wait_term(n0, 50);
        chk("rty_stb_count", stb_log.size(), 5);
        chk("rty_adr1", stb_log[1], 32'h204);
        chk("rty_adr2", stb_log[2], 32'h204);
        chk("rty_adr3", stb_log[3], 32'h204);
        chk("rty_adr4", stb_log[4], 32'h208);
        chk("rty_gaps", gap_cnt, 2);

        // Retries exhausted
        stb_log = {};
        resp_q = {2, 2, 2, 2, 2};
        push_term(KE, 2'd2, 0, 0, 0);
        n0 = term_cnt;
        start(0, 32'h300, 4'hF, 2);
        wait_term(n0, 50);
        chk("rtyx_stb_count", stb_log.size(), 5);
        chk("rtyx_adr", stb_log[4], 32'h300);
        chk("rtyx_code_hold", mast_err_code, 2'd2);

        // Bus error with simultaneous ack on beat 2 of 4
        resp_q = {1, 4};
        rdata_q = {32'hC0, 32'hC1};
        push_beat(32'h400, 0, 0, 4'hF, 0);
        push_term(KE, 2'd1, 32'hC0, 1, 0);
        n0 = term_cnt;
        start(0, 32'h400, 4'hF, 4);
        wait_term(n0, 50);

        // Timeout on a silent slave; a go while busy must be ignored
        slave_default = 0; stall_cnt = 0; stb_log = {};
        push_term(KE, 2'd3, 0, 0, 0);
        n0 = term_cnt;
        start(0, 32'h500, 4'hF, 1);
        repeat (5) @(negedge clk);
        mast_adr = 32'h900; mast_go = 1;
        @(negedge clk);
        mast_go = 0;
        wait_term(n0, 400);
        slave_default = 1;
        chk("tout_stalls", stall_cnt, 255);
        chk("busy_go_ignored", stb_log[stb_log.size() - 1], 32'h500);

        // Zero-length request
        cyc_cnt = 0;
        push_term(KD, 2'd0, 32'hC0, 1, 0);
        n0 = term_cnt;
        start(0, 32'h800, 4'hF, 0);
        wait_term(n0, 10);
        chk("len0_no_cyc", cyc_cnt, 0);

        // Pass-through
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            pv = {32'h1234_5678 ^ (i * 32'h1111_1111), 32'hFEDC_0000 + i, 4'h5 << i, 3'(i + 5)};
            pt_sel = 1; mast_pt_in = pv;
            #1;
            chk("pt_bus", {wb_data_o, wb_addr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o}, pv);
            chk("pt_out", mast_pt_out, {wb_data_i, wb_ack_i, wb_err_i, wb_rty_i});
        end
        @(negedge clk); #1;
        pt_sel = 0;
        #1 chk("pt_release", {wb_cyc_o, wb_stb_o}, 2'b00);

        // Reset mid-burst
        slave_default = 0;
        n0 = term_cnt;
        start(0, 32'h700, 4'hF, 8);
        repeat (3) @(negedge clk);
        #1 rst = 1;
        #1 chk("rst_mid", {wb_cyc_o, wb_stb_o, mast_busy}, 3'b000);
        repeat (3) @(negedge clk);
        chk("rst_no_term", term_cnt, n0);
        rst = 0;
        slave_default = 1;
        repeat (3) @(negedge clk);
        chk("rst_no_term_after", term_cnt, n0);
        chk("sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_dma_wb_mast_burst.md
Name: wb_dma_wb_mast_burst

Overview:
- Parametrised next-generation WISHBONE master for the DMA engine.
- Runs whole bursts of up to BURST_MAX beats from one request, instead of following a level-held go line.
- Adds auto address increment, per-request byte selects, bounded retry on wb_rty_i, a bus-timeout watchdog, and done/error status with an error code.
- Keeps the pass-through mux that hands the bus to an external master.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 32, address width in bits.
- BURST_MAX, 8, maximum beats per request; LW = clog2(BURST_MAX+1).
- RTY_MAX, 4, retries allowed per beat before an error is raised.
- TOUT, 255, stalled-strobe cycles before a timeout error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- wb_data_i  in  DW  slave read data.
- wb_data_o  out  DW  write data.
- wb_addr_o  out  AW  address.
- wb_sel_o  out  DW/8  byte selects.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  bus error.
- wb_rty_i  in  1  retry.
- mast_go  in  1  start-request pulse; sampled only in IDLE.
- mast_we  in  1  burst direction, 1 = write.
- mast_adr  in  AW  start address.
- mast_sel  in  DW/8  byte selects used for every beat.
- mast_len  in  LW  beat count.
- mast_din  in  DW  write data for the current beat.
- mast_dout  out  DW  last read data.
- mast_drdy  out  1  one-cycle pulse per completed beat.
- mast_wait  in  1  insert wait states.
- mast_busy  out  1  burst in progress.
- mast_done  out  1  one-cycle pulse on good completion.
- mast_err  out  1  one-cycle pulse on failure.
- mast_err_code  out  2  failure cause: 0 none, 1 bus err, 2 retry exhausted, 3 timeout.
- pt_sel  in  1  pass-through select.
- mast_pt_in  in  DW+AW+DW/8+3  packed {data,addr,sel,we,cyc,stb} from the external master.
- mast_pt_out  out  DW+3  packed {wb_data_i,wb_ack_i,wb_err_i,wb_rty_i}.

Behaviour:
- Reset values: every registered output is 0, the state is IDLE, and all counters are 0. Reset mid-burst drops wb_cyc_o/wb_stb_o immediately and asynchronously, with no done or err pulse.

WISHBONE output mux:
- When pt_sel=1, {wb_data_o,wb_addr_o,wb_sel_o,wb_we_o,wb_cyc_o,wb_stb_o} = mast_pt_in.
- When pt_sel=0, the same bus = {mast_din, adr_r, sel_r, we_r, cyc_r, stb_r}.
- mast_pt_out is always driven as its packed inputs.
- The FSM runs regardless of pt_sel.

IDLE:
- mast_go=1 with mast_len!=0: latch adr, sel, we and len; beat count = 0. Next cycle cyc_r=1, stb_r=!mast_wait, busy=1, state BUS, err_code cleared.
- mast_go=1 with mast_len=0: no bus cycle; mast_done pulses the next cycle and err_code is cleared.

BUS: cyc_r=1; stb_r registered each cycle as !mast_wait. In each cycle with stb_r=1, exactly one of the following applies, in priority order err > rty > ack:
- err: go to ERR with code 1.
- rty: stb_r=0 for exactly one cycle (RGAP), retry count +1. If the retry count would exceed RTY_MAX, go to ERR with code 2. The same beat is reissued at the same address.
- ack:
  - mast_drdy pulses in that cycle (combinational from ack & stb_r & state BUS).
  - On a read, mast_dout <= wb_data_i.
  - adr_r += DW/8, wrapping modulo 2^AW.
  - Beat count +1 and retry count cleared.
  - If the beat count reaches len, go to DONE.
- Write data: mast_din drives wb_data_o directly. The source must advance mast_din on the clock edge where mast_drdy=1.
- Timeout counter:
  - Increments each cycle with stb_r=1 and no ack/err/rty.
  - Clears on any response or when stb_r=0.
  - Reaching TOUT goes to ERR with code 3.
- Acks while stb_r=0 are ignored.

DONE:
- cyc_r=0, stb_r=0, busy=0; mast_done=1 for one cycle; then IDLE.

ERR:
- cyc_r=0, stb_r=0, busy=0; mast_err=1 for one cycle; then IDLE.
- err_code holds until the next accepted mast_go.

Timing and request handling:
- Latency from mast_go to the first wb_stb_o is 1 cycle.
- A zero-wait slave with ack in every stb cycle gives one beat per clock.
- mast_go while busy is ignored.

Test Plan:
- Read burst: go, adr=0x100, len=4, sel=0xF, slave acks every cycle with data 0xA0..0xA3 -> addresses 0x100/0x104/0x108/0x10C; 4 drdy pulses; mast_dout=0xA3; done 1 cycle after the last ack; cyc low.
- Write with waits: len=3, mast_wait high for 2 cycles mid-burst -> stb low exactly those cycles; cyc stays high; 3 beats; wb_data_o tracks mast_din.
- Retry: rty on beat 1 twice, then ack -> one-cycle stb gaps, same address each retry, burst completes. RTY_MAX+1 rty in a row -> err pulse, code 2, cyc low.
- Bus error on beat 2 of 4 (with simultaneous ack) -> err wins; code 1; only 1 drdy counted; no done.
- Timeout: slave never responds -> err pulse after TOUT=255 stalled cycles, code 3. len=0 request -> done pulse with no cyc.
- Pass-through and reset: pt_sel=1 -> WB outputs equal mast_pt_in bit-exact. Assert rst mid-burst -> cyc/stb/busy go 0 immediately; no done/err pulse.
